// File: rtl/sa_ar_channel.sv
// Slave-side AR stage: round-robin arbitration over the master dispatchers, master-index
// ID prefixing, and 4 KB boundary splitting of INCR bursts with a push strobe to the R stage.
module sa_ar_channel #(
    parameter int MST_AMT        = 3,
    parameter int MST_ID_W       = $clog2(MST_AMT),
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TRANS_MST_ID_W = 5,
    parameter int TRANS_SLV_ID_W = TRANS_MST_ID_W + MST_ID_W
) (
    input  logic                               ACLK_i,
    input  logic                               ARESETn_i,
    input  logic [TRANS_MST_ID_W*MST_AMT-1:0]  dsp_ARID_i,
    input  logic [ADDR_WIDTH*MST_AMT-1:0]      dsp_ARADDR_i,
    input  logic [8*MST_AMT-1:0]               dsp_ARLEN_i,
    input  logic [2*MST_AMT-1:0]               dsp_ARBURST_i,
    input  logic [MST_AMT-1:0]                 dsp_ARVALID_i,
    output logic [MST_AMT-1:0]                 dsp_ARREADY_o,
    output logic [TRANS_SLV_ID_W-1:0]          s_ARID_o,
    output logic [ADDR_WIDTH-1:0]              s_ARADDR_o,
    output logic [7:0]                         s_ARLEN_o,
    output logic [1:0]                         s_ARBURST_o,
    output logic                               s_ARVALID_o,
    input  logic                               s_ARREADY_i,
    output logic [TRANS_SLV_ID_W-1:0]          AR_AxID_o,
    output logic                               AR_crossing_flag_o,
    output logic                               AR_shift_en_o,
    input  logic                               AR_stall_i
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int PW    = ADDR_WIDTH - 12;
    localparam logic [1:0]          BURST_INCR = 2'b01;
    localparam logic [MST_ID_W-1:0] LAST_RST   = MST_ID_W'(MST_AMT - 1);

    typedef enum logic [1:0] {IDLE, SEND, SPLIT_WAIT, SEND2} state_t;

    state_t                      state_q, state_d;
    logic [MST_ID_W-1:0]         last_grant_q;
    logic [MST_ID_W-1:0]         mst_q;
    logic [TRANS_MST_ID_W-1:0]   id_q;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic [7:0]                  len_q;
    logic [1:0]                  burst_q;

    logic                        gnt_vld;
    logic [MST_ID_W-1:0]         gnt_idx;
    logic                        accept;
    logic [TRANS_MST_ID_W-1:0]   req_id;
    logic [ADDR_WIDTH-1:0]       req_addr;
    logic [7:0]                  req_len;
    logic [1:0]                  req_burst;

    logic [12:0]                 bytes_left;
    logic [10:0]                 btb;
    logic                        split;
    logic [7:0]                  first_len;
    logic [7:0]                  second_len;
    logic [ADDR_WIDTH-1:0]       second_addr;

    // Round-robin search starting one past the last winner.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= MST_AMT; k++) begin
            for (int m = 0; m < MST_AMT; m++) begin
                if (!gnt_vld && dsp_ARVALID_i[m] && ((int'(last_grant_q) + k) % MST_AMT) == m) begin
                    gnt_vld = 1'b1;
                    gnt_idx = MST_ID_W'(m);
                end
            end
        end
    end

    // ARESETn_i gating keeps ARREADY low while reset is held, so no request is lost.
    assign accept = ARESETn_i && (state_q == IDLE) && gnt_vld && !AR_stall_i;

    always_comb begin
        req_id    = '0;
        req_addr  = '0;
        req_len   = '0;
        req_burst = '0;
        for (int m = 0; m < MST_AMT; m++) begin
            if (gnt_idx == MST_ID_W'(m)) begin
                req_id    = dsp_ARID_i[m*TRANS_MST_ID_W +: TRANS_MST_ID_W];
                req_addr  = dsp_ARADDR_i[m*ADDR_WIDTH +: ADDR_WIDTH];
                req_len   = dsp_ARLEN_i[m*8 +: 8];
                req_burst = dsp_ARBURST_i[m*2 +: 2];
            end
        end
    end

    assign bytes_left  = 13'h1000 - {1'b0, addr_q[11:0]};
    assign btb         = 11'(bytes_left >> BSH);
    assign split       = (burst_q == BURST_INCR) && (({3'b000, len_q} + 11'd1) > btb);
    assign first_len   = 8'(btb - 11'd1);
    assign second_len  = len_q - btb[7:0];
    assign second_addr = {addr_q[ADDR_WIDTH-1:12] + PW'(1), 12'h000};

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_RST;
            mst_q        <= '0;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            burst_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= gnt_idx;
                mst_q        <= gnt_idx;
                id_q         <= req_id;
                addr_q       <= req_addr;
                len_q        <= req_len;
                burst_q      <= req_burst;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (accept) state_d = SEND;
            SEND:       if (s_ARREADY_i) state_d = split ? SPLIT_WAIT : IDLE;
            SPLIT_WAIT: if (!AR_stall_i) state_d = SEND2;
            SEND2:      if (s_ARREADY_i) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Slave-side fields are driven only while a request is presented.
    always_comb begin
        s_ARVALID_o        = 1'b0;
        s_ARID_o           = '0;
        s_ARADDR_o         = '0;
        s_ARLEN_o          = '0;
        s_ARBURST_o        = '0;
        AR_crossing_flag_o = 1'b0;
        case (state_q)
            SEND: begin
                s_ARVALID_o        = 1'b1;
                s_ARID_o           = {mst_q, id_q};
                s_ARADDR_o         = addr_q;
                s_ARLEN_o          = split ? first_len : len_q;
                s_ARBURST_o        = burst_q;
                AR_crossing_flag_o = split;
            end
            SEND2: begin
                s_ARVALID_o = 1'b1;
                s_ARID_o    = {mst_q, id_q};
                s_ARADDR_o  = second_addr;
                s_ARLEN_o   = second_len;
                s_ARBURST_o = burst_q;
            end
            default: ;
        endcase
        dsp_ARREADY_o = '0;
        for (int m = 0; m < MST_AMT; m++) begin
            dsp_ARREADY_o[m] = accept && (gnt_idx == MST_ID_W'(m));
        end
    end

    assign AR_AxID_o     = s_ARID_o;
    assign AR_shift_en_o = s_ARVALID_o & s_ARREADY_i;

endmodule

// File: tb/tb_sa_ar_channel.sv
// Bench for sa_ar_channel: directed cases from the test plan plus randomized traffic
// checked against a transaction-level model of grants and 4 KB splitting.
module tb_sa_ar_channel;

    localparam int NM = 3;
    localparam int IW = 5;
    localparam int SW = 7;
    localparam int AW = 32;
    localparam int FW = SW + AW + 8 + 2 + 1;

    typedef struct {
        logic [SW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [1:0]    burst;
        logic          flag;
    } ar_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [IW-1:0]     m_id    [NM];
    logic [AW-1:0]     m_addr  [NM];
    logic [7:0]        m_len   [NM];
    logic [1:0]        m_burst [NM];
    logic [NM-1:0]     m_vld;
    logic              s_rdy;
    logic              stall;

    logic [IW*NM-1:0]  dsp_ARID;
    logic [AW*NM-1:0]  dsp_ARADDR;
    logic [8*NM-1:0]   dsp_ARLEN;
    logic [2*NM-1:0]   dsp_ARBURST;
    logic [NM-1:0]     dsp_ARREADY;
    logic [SW-1:0]     s_ARID, AR_AxID;
    logic [AW-1:0]     s_ARADDR;
    logic [7:0]        s_ARLEN;
    logic [1:0]        s_ARBURST;
    logic              s_ARVALID, AR_crossing_flag, AR_shift_en;

    always_comb begin
        dsp_ARID    = '0;
        dsp_ARADDR  = '0;
        dsp_ARLEN   = '0;
        dsp_ARBURST = '0;
        for (int i = 0; i < NM; i++) begin
            dsp_ARID[i*IW +: IW]   = m_id[i];
            dsp_ARADDR[i*AW +: AW] = m_addr[i];
            dsp_ARLEN[i*8 +: 8]    = m_len[i];
            dsp_ARBURST[i*2 +: 2]  = m_burst[i];
        end
    end

    sa_ar_channel dut (
        .ACLK_i             (clk),
        .ARESETn_i          (rst_n),
        .dsp_ARID_i         (dsp_ARID),
        .dsp_ARADDR_i       (dsp_ARADDR),
        .dsp_ARLEN_i        (dsp_ARLEN),
        .dsp_ARBURST_i      (dsp_ARBURST),
        .dsp_ARVALID_i      (m_vld),
        .dsp_ARREADY_o      (dsp_ARREADY),
        .s_ARID_o           (s_ARID),
        .s_ARADDR_o         (s_ARADDR),
        .s_ARLEN_o          (s_ARLEN),
        .s_ARBURST_o        (s_ARBURST),
        .s_ARVALID_o        (s_ARVALID),
        .s_ARREADY_i        (s_rdy),
        .AR_AxID_o          (AR_AxID),
        .AR_crossing_flag_o (AR_crossing_flag),
        .AR_shift_en_o      (AR_shift_en),
        .AR_stall_i         (stall)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    ar_t           exp_q[$];
    logic [FW-1:0] obs_log[$];
    int            gnt_log[$];
    int            last_g = NM - 1;
    bit            busy = 0;
    logic [NM-1:0] gnt_pending = '0;
    int            hs_count = 0;
    int            n_shift = 0;

    // Expected slave transactions for one master request, from the 4 KB rule.
    task automatic push_expected(input int m);
        ar_t e;
        int  off, btb, beats;
        off   = int'(m_addr[m][11:0]);
        btb   = (4096 - off) / 4;
        beats = int'(m_len[m]) + 1;
        e.id    = SW'((m << IW) | int'(m_id[m]));
        e.burst = m_burst[m];
        if (m_burst[m] == 2'b01 && beats > btb) begin
            e.addr = m_addr[m];
            e.len  = 8'(btb - 1);
            e.flag = 1'b1;
            exp_q.push_back(e);
            e.addr = 32'((longint'(m_addr[m]) / 4096 + 1) * 4096);
            e.len  = 8'(beats - btb - 1);
            e.flag = 1'b0;
            exp_q.push_back(e);
        end else begin
            e.addr = m_addr[m];
            e.len  = m_len[m];
            e.flag = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    int            g, c;
    logic [NM-1:0] er;
    logic [FW-1:0] cur, prev_fields;
    logic          prev_vld = 0, prev_rdy = 0, prev_stall = 0, prev_grant = 0;
    bit            sw_active = 0, sw_go = 0;
    ar_t           e_m;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_g = NM - 1;
            busy = 0;
            exp_q.delete();
            prev_vld = 0; prev_rdy = 0; prev_stall = 0; prev_grant = 0;
            sw_active = 0; sw_go = 0;
        end else begin
            g = -1;
            if (!busy && !stall && m_vld != '0) begin
                for (int k = 1; k <= NM; k++) begin
                    c = (last_g + k) % NM;
                    if (g < 0 && m_vld[c]) g = c;
                end
            end
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            check_val("arready", dsp_ARREADY, er);
            cur = {s_ARID, s_ARADDR, s_ARLEN, s_ARBURST, AR_crossing_flag};
            if (prev_grant) check_val("accept_to_valid", s_ARVALID, 1);
            if (prev_vld && !prev_rdy) begin
                check_val("hold_valid", s_ARVALID, 1);
                check_val("hold_fields", cur, prev_fields);
            end
            if (s_ARVALID && !prev_vld) check_val("rise_under_stall", prev_stall, 0);
            if (sw_active) begin
                if (sw_go) begin
                    check_val("second_half_valid", s_ARVALID, 1);
                    sw_active = 0;
                end else begin
                    check_val("split_wait_low", s_ARVALID, 0);
                    sw_go = !stall;
                end
            end
            check_val("shift_en", AR_shift_en, s_ARVALID & s_rdy);
            if (AR_shift_en) n_shift++;
            if (s_ARVALID && s_rdy) begin
                check_val("ar_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e_m = exp_q.pop_front();
                    check_val("arid", s_ARID, e_m.id);
                    check_val("axid", AR_AxID, e_m.id);
                    check_val("araddr", s_ARADDR, e_m.addr);
                    check_val("arlen", s_ARLEN, e_m.len);
                    check_val("arburst", s_ARBURST, e_m.burst);
                    check_val("cross_flag", AR_crossing_flag, e_m.flag);
                    if (e_m.flag) begin
                        sw_active = 1;
                        sw_go = 0;
                    end
                    if (exp_q.size() == 0) busy = 0;
                end
                obs_log.push_back(cur);
                hs_count++;
            end
            prev_grant = 0;
            if (g >= 0 && (dsp_ARREADY & er) != '0) begin
                push_expected(g);
                busy = 1;
                last_g = g;
                gnt_log.push_back(g);
                gnt_pending[g] = 1'b1;
                prev_grant = 1;
            end
            prev_vld = s_ARVALID;
            prev_rdy = s_rdy;
            prev_stall = stall;
            prev_fields = cur;
        end
    end

    task automatic set_req(input int m, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        m_id[m] = id; m_addr[m] = addr; m_len[m] = len; m_burst[m] = burst;
        m_vld[m] = 1'b1;
    endtask

    task automatic new_req(input int m);
        logic [31:0] r;
        logic [11:0] off12;
        logic [19:0] page;
        int t;
        r = $urandom;
        m_id[m] = r[4:0];
        r = $urandom;
        if ($urandom_range(3) < 2) off12 = 12'(4096 - 4 * $urandom_range(1, 24));
        else                       off12 = {r[11:2], 2'b00};
        page = ($urandom_range(15) == 0) ? 20'hFFFFF : r[31:12];
        m_addr[m] = {page, off12};
        m_len[m] = ($urandom_range(7) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(15));
        t = $urandom_range(3);
        m_burst[m] = (t == 0) ? 2'b00 : (t == 3) ? 2'b10 : 2'b01;
        m_vld[m] = 1'b1;
    endtask

    task automatic wait_grant(input int m);
        for (int i = 0; i < 100 && !gnt_pending[m]; i++) begin
            @(posedge clk); #1;
        end
        check_val("grant_wait", gnt_pending[m], 1);
        gnt_pending[m] = 1'b0;
        m_vld[m] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && (busy || exp_q.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        check_val("idle_wait", busy, 0);
    endtask

    task automatic wait_hs(input int target);
        for (int i = 0; i < 100 && hs_count < target; i++) begin
            @(posedge clk); #1;
        end
        check_val("hs_wait", hs_count >= target, 1);
    endtask

    int h0, s0;

    initial begin
        rst_n = 1'b0;
        s_rdy = 1'b1;
        stall = 1'b0;
        m_vld = '0;
        for (int i = 0; i < NM; i++) set_req(i, IW'(i + 1), AW'(32'h100 * (i + 1)), 8'd1, 2'b01);

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_arvalid", s_ARVALID, 0);
        check_val("rst_arready", dsp_ARREADY, 0);
        check_val("rst_arid", s_ARID, 0);
        check_val("rst_araddr", s_ARADDR, 0);
        check_val("rst_arlen", s_ARLEN, 0);
        check_val("rst_arburst", s_ARBURST, 0);
        check_val("rst_flag", AR_crossing_flag, 0);
        check_val("rst_axid", AR_AxID, 0);
        check_val("rst_shift", AR_shift_en, 0);

        // Round-robin with all masters requesting continuously
        rst_n = 1'b1;
        for (int i = 0; i < 60 && gnt_log.size() < 6; i++) begin
            @(posedge clk); #1;
            for (int m = 0; m < NM; m++) if (gnt_pending[m]) gnt_pending[m] = 1'b0;
        end
        @(posedge clk); #1;
        gnt_pending = '0;
        m_vld = '0;
        wait_idle();
        check_val("rr_count", gnt_log.size() >= 6, 1);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++) check_val("rr_order", gnt_log[i], i % 3);

        // Single INCR
        h0 = hs_count; s0 = n_shift;
        set_req(1, 5'd5, 32'h100, 8'd3, 2'b01);
        wait_grant(1);
        wait_idle();
        check_val("single_hs", hs_count - h0, 1);
        check_val("single_shift", n_shift - s0, 1);
        check_val("single_fields", obs_log[obs_log.size()-1], {7'h25, 32'h100, 8'd3, 2'b01, 1'b0});

        // 4 KB split
        h0 = hs_count; s0 = n_shift;
        set_req(0, 5'd0, 32'hFF8, 8'd7, 2'b01);
        wait_grant(0);
        wait_idle();
        check_val("split_hs", hs_count - h0, 2);
        check_val("split_shift", n_shift - s0, 2);
        check_val("split_first", obs_log[obs_log.size()-2], {7'h00, 32'hFF8, 8'd1, 2'b01, 1'b1});
        check_val("split_second", obs_log[obs_log.size()-1], {7'h00, 32'h1000, 8'd5, 2'b01, 1'b0});

        // WRAP and FIXED never split
        h0 = hs_count;
        set_req(2, 5'd3, 32'hFF8, 8'd3, 2'b10);
        wait_grant(2);
        wait_idle();
        check_val("wrap_fields", obs_log[obs_log.size()-1], {7'h43, 32'hFF8, 8'd3, 2'b10, 1'b0});
        set_req(2, 5'd3, 32'hFF8, 8'd7, 2'b00);
        wait_grant(2);
        wait_idle();
        check_val("fixed_fields", obs_log[obs_log.size()-1], {7'h43, 32'hFF8, 8'd7, 2'b00, 1'b0});
        check_val("nonincr_hs", hs_count - h0, 2);

        // Stall in IDLE blocks grants
        stall = 1'b1;
        set_req(2, 5'd9, 32'h200, 8'd0, 2'b01);
        repeat (5) begin
            @(negedge clk);
            check_val("stall_idle_rdy", dsp_ARREADY, 0);
        end
        @(posedge clk); #1;
        stall = 1'b0;
        wait_grant(2);
        wait_idle();

        // Stall raised after the first half of a split
        h0 = hs_count;
        set_req(0, 5'd7, 32'h2FF0, 8'd7, 2'b01);
        wait_grant(0);
        wait_hs(h0 + 1);
        stall = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_val("stall_split_low", s_ARVALID, 0);
        end
        @(posedge clk); #1;
        stall = 1'b0;
        wait_idle();
        check_val("stall_split_second", obs_log[obs_log.size()-1], {7'h07, 32'h3000, 8'd3, 2'b01, 1'b0});

        // Backpressure: request must hold with no push
        s_rdy = 1'b0;
        s0 = n_shift;
        set_req(1, 5'd2, 32'h400, 8'd2, 2'b01);
        wait_grant(1);
        repeat (5) begin
            @(negedge clk);
            check_val("bp_valid", s_ARVALID, 1);
            check_val("bp_shift", AR_shift_en, 0);
        end
        check_val("bp_no_push", n_shift - s0, 0);
        @(posedge clk); #1;
        s_rdy = 1'b1;
        wait_idle();

        // Reset while waiting for the second half
        h0 = hs_count;
        set_req(2, 5'd1, 32'h0FFC, 8'd3, 2'b01);
        wait_grant(2);
        wait_hs(h0 + 1);
        stall = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_valid", s_ARVALID, 0);
        check_val("rst_mid_addr", s_ARADDR, 0);
        check_val("rst_mid_len", s_ARLEN, 0);
        check_val("rst_mid_id", s_ARID, 0);
        gnt_pending = '0;
        m_vld = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        stall = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check_val("rst_no_second", s_ARVALID, 0);
        end

        // Randomized traffic
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int m = 0; m < NM; m++) begin
                if (gnt_pending[m]) begin
                    gnt_pending[m] = 1'b0;
                    m_vld[m] = 1'b0;
                end
                if (!m_vld[m] && $urandom_range(99) < 30) new_req(m);
            end
            s_rdy = ($urandom_range(3) != 0);
            stall = ($urandom_range(7) == 0);
            @(posedge clk); #1;
        end

        // Drain
        s_rdy = 1'b1;
        stall = 1'b0;
        for (int i = 0; i < 2000 && (m_vld != '0 || busy || exp_q.size() != 0); i++) begin
            for (int m = 0; m < NM; m++) begin
                if (gnt_pending[m]) begin
                    gnt_pending[m] = 1'b0;
                    m_vld[m] = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        check_val("drain_empty", exp_q.size(), 0);
        check_val("drain_masters", m_vld, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
